// File: rtl/pulse_edge_gen_pkg.sv
// pulse_edge_gen_pkg: state encodings and helpers shared by the pulse generator. Rev 1.0
`default_nettype none

package pulse_edge_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int pend_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pulse_edge_gen_counter.sv
// sat_up_down_counter: saturating up/down counter holding the queued-trigger count. Rev 1.0
`default_nettype none

module sat_up_down_counter
    import pulse_edge_gen_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(pend_max(WIDTH));
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Simultaneous inc and dec cancel, so a full counter can still swap one entry.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != MAX_VAL)) begin
            count_d = count_q + ONE;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = (count_q == MAX_VAL);

endmodule

`default_nettype wire

// File: rtl/pulse_edge_gen.sv
// pulse_edge_gen: turns trigger pulses into timed high pulses with a mandatory low gap. Rev 1.0
`default_nettype none

module pulse_edge_gen
    import pulse_edge_gen_pkg::*;
#(
    parameter int CNT_BITS  = 16,
    parameter int PEND_BITS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 trig,
    input  logic [CNT_BITS-1:0]  high_cycles,
    input  logic [CNT_BITS-1:0]  low_cycles,
    input  logic                 clr_ovf,
    output logic                 signal_out,
    output logic                 busy,
    output logic [PEND_BITS-1:0] pending,
    output logic                 overflow
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                sig_q, sig_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic [CNT_BITS-1:0]  high_load;
    logic [CNT_BITS-1:0]  low_load;
    logic [PEND_BITS-1:0] pend_cnt;
    logic                 pend_sat;
    logic                 pend_nz;
    logic                 start;
    logic                 pend_inc;
    logic                 pend_dec;
    logic                 trig_lost;

    // A zero width behaves as one cycle, so the loaded count never underflows.
    assign high_load = (high_cycles == '0) ? '0 : (high_cycles - CNT_ONE);
    assign low_load  = (low_cycles  == '0) ? '0 : (low_cycles  - CNT_ONE);
    assign pend_nz   = (pend_cnt != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start = trig || pend_nz;
            end
            ST_HIGH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_GAP;
                    sig_d   = 1'b0;
                    cnt_d   = low_load;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (trig || pend_nz) begin
                    start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (start) begin
            state_d = ST_HIGH;
            sig_d   = 1'b1;
            cnt_d   = high_load;
        end
        busy_d = (state_d != ST_IDLE);

        // A start consumes trig itself when nothing is queued; otherwise it
        // dequeues the oldest entry and any trig this cycle takes its place.
        pend_dec  = start && pend_nz;
        pend_inc  = trig && !(start && !pend_nz);
        trig_lost = pend_inc && !pend_dec && pend_sat;

        ovf_d = ovf_q;
        if (trig_lost) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    sat_up_down_counter #(
        .WIDTH (PEND_BITS)
    ) u_pend (
        .clk    (clk),
        .resetn (resetn),
        .inc    (pend_inc),
        .dec    (pend_dec),
        .count  (pend_cnt),
        .sat    (pend_sat)
    );

    assign signal_out = sig_q;
    assign busy       = busy_q;
    assign pending    = pend_cnt;
    assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_edge_gen.sv
// tb_pulse_edge_gen: directed and randomized checks against a cycle-schedule reference model. Rev 1.0
`default_nettype none

module tb_pulse_edge_gen;

    localparam int CNT_BITS  = 16;
    localparam int PEND_BITS = 4;
    localparam int PMAX      = (1 << PEND_BITS) - 1;
    localparam longint NEVER = 64'sh3FFF_FFFF_FFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 trig = 1'b0;
    logic                 clr_ovf = 1'b0;
    logic [CNT_BITS-1:0]  high_cycles = '0;
    logic [CNT_BITS-1:0]  low_cycles = '0;
    logic                 signal_out;
    logic                 busy;
    logic [PEND_BITS-1:0] pending;
    logic                 overflow;

    int checks = 0;
    int failures = 0;

    // Model: absolute edge numbers at which the current pulse's high and gap phases end.
    longint cyc = 0;
    bit     m_active;
    longint m_hi_end;
    longint m_gap_end;
    int     m_pend;
    bit     m_ovf;

    bit     prev_sig;
    longint last_rise;
    longint rise_gap;
    int     rise_cnt;
    int     high_cnt;
    int     busy_cnt;
    int     thr;

    always #5 clk = ~clk;

    pulse_edge_gen #(
        .CNT_BITS  (CNT_BITS),
        .PEND_BITS (PEND_BITS)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .trig        (trig),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .clr_ovf     (clr_ovf),
        .signal_out  (signal_out),
        .busy        (busy),
        .pending     (pending),
        .overflow    (overflow)
    );

    function automatic longint eff(input logic [CNT_BITS-1:0] v);
        return (v == '0) ? 64'sd1 : longint'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_hi_end  = 0;
        m_gap_end = NEVER;
        m_pend    = 0;
        m_ovf     = 1'b0;
        prev_sig  = 1'b0;
    endtask

    task automatic model_edge();
        bit lost;
        cyc++;
        if (!resetn) begin
            model_reset();
            return;
        end
        lost = 1'b0;
        if (m_active && cyc == m_hi_end) m_gap_end = cyc + eff(low_cycles);
        if (!m_active || cyc == m_gap_end) begin
            if (trig || m_pend > 0) begin
                if (!trig) m_pend--;
                m_active  = 1'b1;
                m_hi_end  = cyc + eff(high_cycles);
                m_gap_end = NEVER;
            end else begin
                m_active = 1'b0;
            end
        end else if (trig) begin
            if (m_pend < PMAX) m_pend++;
            else lost = 1'b1;
        end
        if (lost) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("signal_out", 32'(signal_out), 32'(m_active && (cyc < m_hi_end)));
        chk("busy", 32'(busy), 32'(m_active));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (signal_out === 1'b1 && !prev_sig) begin
            rise_cnt++;
            rise_gap  = cyc - last_rise;
            last_rise = cyc;
        end
        prev_sig = (signal_out === 1'b1);
        if (signal_out === 1'b1) high_cnt++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic drive(input bit t, input bit c);
        trig    = t;
        clr_ovf = c;
        tick();
        trig    = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with trig toggling
        model_reset();
        for (int i = 0; i < 5; i++) drive(i[0], 1'b0);
        chk("rst_signal_out", 32'(signal_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        resetn = 1'b1;
        idle(2);

        // Single pulse: 3 high, 2 low
        high_cycles = 16'd3;
        low_cycles  = 16'd2;
        high_cnt = 0;
        busy_cnt = 0;
        drive(1'b1, 1'b0);
        idle(9);
        chk("single_high_len", 32'(high_cnt), 32'd3);
        chk("single_busy_len", 32'(busy_cnt), 32'd5);
        chk("single_idle", 32'(busy), 32'd0);

        // Zero widths behave as one cycle
        high_cycles = 16'd0;
        low_cycles  = 16'd0;
        high_cnt = 0;
        drive(1'b1, 1'b0);
        idle(4);
        chk("zero_high_len", 32'(high_cnt), 32'd1);
        rise_cnt = 0;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        idle(6);
        chk("zero_pulse_count", 32'(rise_cnt), 32'd2);
        chk("zero_pulse_spacing", 32'(rise_gap), 32'd2);

        // Queue of three triggers during the first pulse
        high_cycles = 16'd4;
        low_cycles  = 16'd4;
        rise_cnt = 0;
        drive(1'b1, 1'b0);
        repeat (3) drive(1'b1, 1'b0);
        chk("queue_pending", 32'(pending), 32'd3);
        idle(40);
        chk("queue_pulse_count", 32'(rise_cnt), 32'd4);
        chk("queue_period", 32'(rise_gap), 32'd8);
        chk("queue_drained", 32'(pending), 32'd0);

        // Saturation of the pending queue and sticky overflow
        high_cycles = 16'd100;
        low_cycles  = 16'd1;
        drive(1'b1, 1'b0);
        repeat (17) drive(1'b1, 1'b0);
        chk("ovf_pending_sat", 32'(pending), 32'd15);
        chk("ovf_set", 32'(overflow), 32'd1);
        drive(1'b1, 1'b1);
        chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
        drive(1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        resetn = 1'b0;
        drive(1'b0, 1'b0);
        resetn = 1'b1;

        // Asynchronous reset in the middle of a 10-cycle pulse with two queued
        high_cycles = 16'd10;
        low_cycles  = 16'd3;
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("async_pre_pending", 32'(pending), 32'd2);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_signal_out", 32'(signal_out), 32'd0);
        chk("async_pending", 32'(pending), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        idle(2);
        resetn = 1'b1;
        high_cnt = 0;
        drive(1'b1, 1'b0);
        idle(20);
        chk("async_fresh_high_len", 32'(high_cnt), 32'd10);

        // Randomized traffic, with a dense window that drives the queue into saturation
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                high_cycles = CNT_BITS'($urandom_range(0, 5));
                low_cycles  = CNT_BITS'($urandom_range(0, 5));
            end
            thr = (i >= 1200 && i < 1700) ? 80 : 30;
            drive($urandom_range(0, 99) < thr, $urandom_range(0, 29) == 0);
        end
        idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
